usr_shift_sequencer: RTL and testbench

Command-driven controller for the 4-bit universal shift register (usr). It accepts one LOAD/SHIFT/ROTATE command at a time over a valid/ready handshake. It drives the register's sel/pdata/sin for the required number of cycles, then captures the register's q as a result. It sits between a host/control FSM and one universal shift register instance.

---
 rtl/usr_shift_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_usr_shift_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer: command-driven controller for a universal shift register.
// Accepts one LOAD/SHL/SHR/ROTL command at a time over valid/ready, drives the
// register's sel/pdata/sin for the effective number of cycles, then captures
// the register's q into result and pulses done.
//
// Optional feature macro: USR_SEQ_SOUT_EN
//   defined   -> sout/sout_valid report the bit leaving the register on each
//                shift cycle, aligned with the registered usr_sel.
//   undefined -> sout/sout_valid tied to 0.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | cmd_ready=1, register held; accepts a command
// ST_RUN     | one register operation per cycle, rem_q counts down to 0
// ST_CAPTURE | register held, usr_q latched into result, done next cycle
module usr_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       usr_sel,
  output logic [WIDTH-1:0] usr_pdata,
  output logic             usr_sin,
  input  logic [WIDTH-1:0] usr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             sout,
  output logic             sout_valid
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROTL = 2'b11;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_CAPTURE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] sdata_q, sdata_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             sin_q, sin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] eff_cnt;

  // Effective cycle count: LOAD always takes one cycle, shifts clamp at WIDTH.
  always_comb begin
    eff_cnt = cmd_count;
    if (cmd_op == OP_LOAD) begin
      eff_cnt = CNT_W'(1);
    end else if (cmd_count > CNT_W'(WIDTH)) begin
      eff_cnt = CNT_W'(WIDTH);
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // they can be registered and line up with the cycle the register acts.
  // While a shift is being applied at this edge, the post-shift MSB is
  // usr_q[WIDTH-2], which is what ROTL feeds back for the following shift.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rem_d    = rem_q;
    sdata_d  = sdata_q;
    sel_d    = SEL_HOLD;
    pdata_d  = '0;
    sin_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ready_d  = ready_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (cmd_valid && ready_q) begin
          op_d    = cmd_op;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (eff_cnt == '0) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_RUN;
            rem_d   = eff_cnt - CNT_W'(1);
            sdata_d = cmd_data >> 1;
            case (cmd_op)
              OP_LOAD: begin
                sel_d   = SEL_LOAD;
                pdata_d = cmd_data;
              end
              OP_SHL: begin
                sel_d = SEL_LEFT;
                sin_d = cmd_data[0];
              end
              OP_SHR: begin
                sel_d = SEL_RIGHT;
                sin_d = cmd_data[0];
              end
              default: begin
                sel_d = SEL_LEFT;
                sin_d = usr_q[WIDTH-1];
              end
            endcase
          end
        end
      end
      ST_RUN: begin
        if (rem_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          rem_d   = rem_q - CNT_W'(1);
          sdata_d = sdata_q >> 1;
          case (op_q)
            OP_SHL: begin
              sel_d = SEL_LEFT;
              sin_d = sdata_q[0];
            end
            OP_SHR: begin
              sel_d = SEL_RIGHT;
              sin_d = sdata_q[0];
            end
            OP_ROTL: begin
              sel_d = SEL_LEFT;
              sin_d = usr_q[WIDTH-2];
            end
            default: begin
              sel_d = SEL_HOLD;
            end
          endcase
        end
      end
      ST_CAPTURE: begin
        result_d = usr_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        ready_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // FSM state and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOAD;
      rem_q    <= '0;
      sdata_q  <= '0;
      sel_q    <= SEL_HOLD;
      pdata_q  <= '0;
      sin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      sdata_q  <= sdata_d;
      sel_q    <= sel_d;
      pdata_q  <= pdata_d;
      sin_q    <= sin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign cmd_ready = ready_q;
  assign usr_sel   = sel_q;
  assign usr_pdata = pdata_q;
  assign usr_sin   = sin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;

`ifdef USR_SEQ_SOUT_EN
  logic sout_q, sout_d;
  logic sout_valid_q, sout_valid_d;

  // Outgoing bit for the shift issued at this edge: the current MSB/LSB on
  // acceptance, the post-shift neighbour bit while a shift is being applied.
  always_comb begin
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    if (state_q == ST_IDLE && cmd_valid && ready_q &&
        eff_cnt != '0 && cmd_op != OP_LOAD) begin
      sout_valid_d = 1'b1;
      sout_d       = (cmd_op == OP_SHR) ? usr_q[0] : usr_q[WIDTH-1];
    end else if (state_q == ST_RUN && rem_q != '0 && op_q != OP_LOAD) begin
      sout_valid_d = 1'b1;
      sout_d       = (op_q == OP_SHR) ? usr_q[1] : usr_q[WIDTH-2];
    end
  end

  // sout registers, reset alongside the FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
    end else begin
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
`else
  assign sout       = 1'b0;
  assign sout_valid = 1'b0;
`endif

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer with a behavioural 4-bit universal shift
// register closing the loop. Table vectors chain through the register value;
// hand sequences cover reset, back-to-back acceptance and reset mid-command.
module tb_usr_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_count;
  logic [3:0] cmd_data;
  logic [1:0] usr_sel;
  logic [3:0] usr_pdata;
  logic       usr_sin;
  logic [3:0] usr_q;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       sout;
  logic       sout_valid;

  int tests_run = 0;
  int tests_failed = 0;

  usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_count  (cmd_count),
    .cmd_data   (cmd_data),
    .usr_sel    (usr_sel),
    .usr_pdata  (usr_pdata),
    .usr_sin    (usr_sin),
    .usr_q      (usr_q),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .sout       (sout),
    .sout_valid (sout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural universal shift register driven by the sequencer.
  initial usr_q = 4'b0000;
  always @(posedge clk) begin
    case (usr_sel)
      2'b01:   usr_q <= {usr_q[2:0], usr_sin};
      2'b10:   usr_q <= {usr_sin, usr_q[3:1]};
      2'b11:   usr_q <= usr_pdata;
      default: usr_q <= usr_q;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] cnt;
    logic [3:0] data;
    int         n_run;
    logic [1:0] run_sel;
    logic [3:0] sin_seq;
    logic [3:0] sout_seq;
    logic [3:0] exp_result;
  } vec_t;

  vec_t vecs[8];

  // Drive one command, then check every cycle up to and including done.
  task automatic do_cmd(input vec_t v, input int id);
    int  w;
    bit  exp_sv;
    bit  exp_so;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("v%0d ready_wait", id), int'(cmd_ready === 1'b1), 1);
    cmd_op    = v.op;
    cmd_count = v.cnt;
    cmd_data  = v.data;
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= v.n_run + 2; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      exp_sv = 1'b0;
      exp_so = 1'b0;
      if (k <= v.n_run) begin
        chk($sformatf("v%0d c%0d sel", id, k), int'(usr_sel), int'(v.run_sel));
        chk($sformatf("v%0d c%0d busy", id, k), int'(busy), 1);
        chk($sformatf("v%0d c%0d ready", id, k), int'(cmd_ready), 0);
        chk($sformatf("v%0d c%0d done", id, k), int'(done), 0);
        if (v.op == 2'b00)
          chk($sformatf("v%0d c%0d pdata", id, k), int'(usr_pdata), int'(v.data));
        else
          chk($sformatf("v%0d c%0d sin", id, k), int'(usr_sin), int'(v.sin_seq[k-1]));
`ifdef USR_SEQ_SOUT_EN
        if (v.op != 2'b00) begin
          exp_sv = 1'b1;
          exp_so = v.sout_seq[k-1];
        end
`endif
      end else if (k == v.n_run + 1) begin
        chk($sformatf("v%0d capture sel", id), int'(usr_sel), 0);
        chk($sformatf("v%0d capture busy", id), int'(busy), 1);
        chk($sformatf("v%0d capture done", id), int'(done), 0);
      end else begin
        chk($sformatf("v%0d done", id), int'(done), 1);
        chk($sformatf("v%0d done ready", id), int'(cmd_ready), 1);
        chk($sformatf("v%0d done busy", id), int'(busy), 0);
        chk($sformatf("v%0d result", id), int'(result), int'(v.exp_result));
      end
      chk($sformatf("v%0d c%0d sout_valid", id, k), int'(sout_valid), int'(exp_sv));
      chk($sformatf("v%0d c%0d sout", id, k), int'(sout), int'(exp_so));
    end
  endtask

  initial begin
    // op, cnt, data, n_run, run_sel, sin_seq(LSB=first), sout_seq, result
    vecs[0] = '{2'b00, 3'd0, 4'b1010, 1, 2'b11, 4'b0000, 4'b0000, 4'b1010};
    vecs[1] = '{2'b01, 3'd2, 4'b0011, 2, 2'b01, 4'b0011, 4'b0001, 4'b1011};
    vecs[2] = '{2'b10, 3'd3, 4'b0000, 3, 2'b10, 4'b0000, 4'b0011, 4'b0001};
    vecs[3] = '{2'b00, 3'd5, 4'b1010, 1, 2'b11, 4'b0000, 4'b0000, 4'b1010};
    vecs[4] = '{2'b11, 3'd7, 4'b0000, 4, 2'b01, 4'b0101, 4'b0101, 4'b1010};
    vecs[5] = '{2'b01, 3'd0, 4'b1111, 0, 2'b00, 4'b0000, 4'b0000, 4'b1010};
    vecs[6] = '{2'b10, 3'd5, 4'b1101, 4, 2'b10, 4'b1101, 4'b1010, 4'b1101};
    vecs[7] = '{2'b01, 3'd1, 4'b0000, 1, 2'b01, 4'b0000, 4'b0001, 4'b1010};

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = 3'd0;
    cmd_data  = 4'b0000;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst sel", int'(usr_sel), 0);
    chk("rst pdata", int'(usr_pdata), 0);
    chk("rst sin", int'(usr_sin), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst result", int'(result), 0);
    chk("rst sout", int'(sout), 0);
    chk("rst sout_valid", int'(sout_valid), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst ready", int'(cmd_ready), 1);

    for (int i = 0; i < 8; i++) do_cmd(vecs[i], i);

    // Back-to-back: LOAD 0110, second command SHL 1 (data 0001) held valid
    // through the first; it is taken only in the done cycle.
    @(negedge clk);
    cmd_op = 2'b00; cmd_count = 3'd0; cmd_data = 4'b0110; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 2'b01; cmd_count = 3'd1; cmd_data = 4'b0001;
    chk("b2b c1 sel", int'(usr_sel), 3);
    chk("b2b c1 pdata", int'(usr_pdata), 6);
    @(negedge clk);
    chk("b2b c2 sel", int'(usr_sel), 0);
    chk("b2b c2 ready", int'(cmd_ready), 0);
    chk("b2b c2 busy", int'(busy), 1);
    @(negedge clk);
    chk("b2b c3 done", int'(done), 1);
    chk("b2b c3 ready", int'(cmd_ready), 1);
    chk("b2b c3 result", int'(result), 6);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b c4 sel", int'(usr_sel), 1);
    chk("b2b c4 sin", int'(usr_sin), 1);
    chk("b2b c4 busy", int'(busy), 1);
    chk("b2b c4 done", int'(done), 0);
    @(negedge clk);
    chk("b2b c5 sel", int'(usr_sel), 0);
    @(negedge clk);
    chk("b2b c6 done", int'(done), 1);
    chk("b2b c6 result", int'(result), 13);
    @(negedge clk);
    chk("b2b c7 done_drop", int'(done), 0);
    chk("b2b c7 busy", int'(busy), 0);

    // Reset in the middle of SHR 3 (q=1101): one shift applied, the second
    // lands on the reset edge since its sel was already registered.
    cmd_op = 2'b10; cmd_count = 3'd3; cmd_data = 4'b0000; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid c1 sel", int'(usr_sel), 2);
    @(negedge clk);
    chk("mid c2 q", int'(usr_q), 6);
    rst = 1'b0;
    @(negedge clk);
    chk("mid rst sel", int'(usr_sel), 0);
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst done", int'(done), 0);
    chk("mid rst result", int'(result), 0);
    chk("mid rst sout_valid", int'(sout_valid), 0);
    chk("mid rst q", int'(usr_q), 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid post ready", int'(cmd_ready), 1);
    chk("mid post busy", int'(busy), 0);
    chk("mid post q_hold", int'(usr_q), 3);
    @(negedge clk);
    chk("mid idle sel", int'(usr_sel), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
